// File: rtl/parking_monitor.sv
// Parking lot occupancy monitor: per-lane A/B beam FSMs feeding a saturating
// occupancy counter with sticky sequence/overflow/underflow error flags.

// One sensor lane: synchronizes the A/B beams and tracks a car crossing them.
module parking_lane (
    input  logic clk,
    input  logic rst,
    input  logic a_i,
    input  logic b_i,
    input  logic clr_err_i,
    output logic entry_o,
    output logic exit_o,
    output logic err_seq_o
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EN1  = 3'd1;
    localparam logic [2:0] S_EN2  = 3'd2;
    localparam logic [2:0] S_EN3  = 3'd3;
    localparam logic [2:0] S_EX1  = 3'd4;
    localparam logic [2:0] S_EX2  = 3'd5;
    localparam logic [2:0] S_EX3  = 3'd6;
    localparam logic [2:0] S_BAD  = 3'd7;

    logic [1:0] a_sync_q, b_sync_q;
    logic [1:0] ab;
    logic [2:0] state_q, state_d;
    logic       entry_q, entry_d, exit_q, exit_d, err_q, err_d;

    // Two-flop synchronizers; bit 1 is the stage the FSM consumes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
        end else begin
            a_sync_q <= {a_sync_q[0], a_i};
            b_sync_q <= {b_sync_q[0], b_i};
        end
    end

    assign ab = {a_sync_q[1], b_sync_q[1]};

    // Next-state decode; entry path is 10-11-01-00, exit path mirrors it.
    always_comb begin
        state_d = state_q;
        entry_d = 1'b0;
        exit_d  = 1'b0;
        case (state_q)
            S_IDLE: case (ab)
                2'b10:   state_d = S_EN1;
                2'b01:   state_d = S_EX1;
                2'b11:   state_d = S_BAD;
                default: state_d = S_IDLE;
            endcase
            S_EN1: case (ab)
                2'b11:   state_d = S_EN2;
                2'b00:   state_d = S_IDLE;  // backed out, no event
                2'b01:   state_d = S_BAD;
                default: state_d = S_EN1;
            endcase
            S_EN2: case (ab)
                2'b01:   state_d = S_EN3;
                2'b10:   state_d = S_EN1;
                2'b00:   state_d = S_BAD;
                default: state_d = S_EN2;
            endcase
            S_EN3: case (ab)
                2'b00: begin
                    state_d = S_IDLE;
                    entry_d = 1'b1;
                end
                2'b11:   state_d = S_EN2;
                2'b10:   state_d = S_BAD;
                default: state_d = S_EN3;
            endcase
            S_EX1: case (ab)
                2'b11:   state_d = S_EX2;
                2'b00:   state_d = S_IDLE;
                2'b10:   state_d = S_BAD;
                default: state_d = S_EX1;
            endcase
            S_EX2: case (ab)
                2'b10:   state_d = S_EX3;
                2'b01:   state_d = S_EX1;
                2'b00:   state_d = S_BAD;
                default: state_d = S_EX2;
            endcase
            S_EX3: case (ab)
                2'b00: begin
                    state_d = S_IDLE;
                    exit_d  = 1'b1;
                end
                2'b11:   state_d = S_EX2;
                2'b01:   state_d = S_BAD;
                default: state_d = S_EX3;
            endcase
            default: state_d = (ab == 2'b00) ? S_IDLE : S_BAD;
        endcase
    end

    // Only a fresh entry into BAD raises the flag; a set beats a same-cycle clear.
    assign err_d = ((state_d == S_BAD) && (state_q != S_BAD)) | (err_q & ~clr_err_i);

    // FSM state, registered event pulses and sticky sequence error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            entry_q <= 1'b0;
            exit_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            exit_q  <= exit_d;
            err_q   <= err_d;
        end
    end

    assign entry_o   = entry_q;
    assign exit_o    = exit_q;
    assign err_seq_o = err_q;
endmodule

module parking_monitor #(
    parameter int NLANES = 2,
    parameter int CAP    = 15,
    parameter int CW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NLANES-1:0] A,
    input  logic [NLANES-1:0] B,
    input  logic              clr_err,
    output logic [NLANES-1:0] entry,
    output logic [NLANES-1:0] exit,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic [NLANES-1:0] err_seq,
    output logic              err_ovf,
    output logic              err_unf
);
    // Signed headroom for count +/- up to 8 simultaneous lane events.
    localparam int SW = CW + 5;
    localparam logic signed [SW-1:0] CAP_S = SW'(CAP);

    logic signed [SW-1:0] n_ent, n_ext, sum;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, unf_q, ovf_set, unf_set;

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        parking_lane u_lane (
            .clk       (clk),
            .rst       (rst),
            .a_i       (A[i]),
            .b_i       (B[i]),
            .clr_err_i (clr_err),
            .entry_o   (entry[i]),
            .exit_o    (exit[i]),
            .err_seq_o (err_seq[i])
        );
    end

    // Net occupancy change from all lanes this cycle, saturated to 0..CAP.
    always_comb begin
        n_ent = '0;
        n_ext = '0;
        for (int i = 0; i < NLANES; i++) begin
            n_ent = n_ent + SW'(entry[i]);
            n_ext = n_ext + SW'(exit[i]);
        end
        sum     = SW'(count_q) + n_ent - n_ext;
        ovf_set = (sum > CAP_S);
        unf_set = sum[SW-1];
        if (ovf_set)      count_d = CW'(CAP);
        else if (unf_set) count_d = '0;
        else              count_d = sum[CW-1:0];
    end

    // Occupancy register and sticky counter error flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_set | (ovf_q & ~clr_err);
            unf_q   <= unf_set | (unf_q & ~clr_err);
        end
    end

    assign count   = count_q;
    assign full    = (count_q == CW'(CAP));
    assign empty   = (count_q == '0);
    assign err_ovf = ovf_q;
    assign err_unf = unf_q;
endmodule

// File: tb/tb_parking_monitor.sv
// Bench for parking_monitor (NLANES=2, CAP=3, CW=2): directed vector table,
// an exact pulse-latency sequence, then random lane walks against a path model.
module tb_parking_monitor;
    localparam int CAP = 3;

    logic       clk = 1'b0;
    logic       rst, clr_err;
    logic [1:0] A, B;
    logic [1:0] ent_w, ext_w, cnt_w, eseq_w;
    logic       full_w, empty_w, ovf_w, unf_w;

    parking_monitor #(.NLANES(2), .CAP(CAP), .CW(2)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .clr_err(clr_err),
        .entry(ent_w), .exit(ext_w), .count(cnt_w), .full(full_w), .empty(empty_w),
        .err_seq(eseq_w), .err_ovf(ovf_w), .err_unf(unf_w)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int ent_acc, ext_acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each lane is a walker along a 3-point path of beam patterns; leaving the
    // final point with 00 completes the crossing, anything off-path is an error.
    int         m_cnt;
    bit   [1:0] m_ent, m_ext, m_eseq, m_d1a, m_d1b, m_d2a, m_d2b;
    bit         m_ovf, m_unf;
    int         m_pos[2], m_dir[2];
    bit         m_bad[2];

    function automatic logic [1:0] pth(input int dir, input int k);
        logic [1:0] en [3] = '{2'b10, 2'b11, 2'b01};
        logic [1:0] ex [3] = '{2'b01, 2'b11, 2'b10};
        return (dir == 0) ? en[k] : ex[k];
    endfunction

    task automatic m_step();
        int nc;
        bit so, su;
        bit [1:0] ne, nx, sb;
        logic [1:0] ab;
        if (!rst) begin
            m_cnt = 0; m_ent = 0; m_ext = 0; m_eseq = 0; m_ovf = 0; m_unf = 0;
            m_d1a = 0; m_d1b = 0; m_d2a = 0; m_d2b = 0;
            for (int i = 0; i < 2; i++) begin m_pos[i] = 0; m_dir[i] = 0; m_bad[i] = 0; end
            return;
        end
        nc = m_cnt + $countones(m_ent) - $countones(m_ext);
        so = 0; su = 0;
        if (nc > CAP) begin nc = CAP; so = 1; end
        else if (nc < 0) begin nc = 0; su = 1; end
        m_cnt = nc;
        ne = 0; nx = 0; sb = 0;
        for (int i = 0; i < 2; i++) begin
            ab = {m_d2a[i], m_d2b[i]};
            if (m_bad[i]) begin
                if (ab == 2'b00) m_bad[i] = 0;
            end else if (m_pos[i] == 0) begin
                if (ab == pth(0, 0))      begin m_dir[i] = 0; m_pos[i] = 1; end
                else if (ab == pth(1, 0)) begin m_dir[i] = 1; m_pos[i] = 1; end
                else if (ab != 2'b00)     begin m_bad[i] = 1; sb[i] = 1; end
            end else begin
                if (ab == pth(m_dir[i], m_pos[i]-1)) ;
                else if (m_pos[i] < 3 && ab == pth(m_dir[i], m_pos[i])) m_pos[i]++;
                else if (m_pos[i] > 1 && ab == pth(m_dir[i], m_pos[i]-2)) m_pos[i]--;
                else if (ab == 2'b00 && m_pos[i] == 1) m_pos[i] = 0;
                else if (ab == 2'b00 && m_pos[i] == 3) begin
                    m_pos[i] = 0;
                    if (m_dir[i] == 0) ne[i] = 1; else nx[i] = 1;
                end else begin m_bad[i] = 1; m_pos[i] = 0; sb[i] = 1; end
            end
        end
        m_ent  = ne;
        m_ext  = nx;
        m_eseq = sb | (m_eseq & ~{2{clr_err}});
        m_ovf  = so | (m_ovf & ~clr_err);
        m_unf  = su | (m_unf & ~clr_err);
        m_d2a = m_d1a; m_d2b = m_d1b; m_d1a = A; m_d1b = B;
    endtask

    task automatic cyc();
        @(posedge clk);
        m_step();
        @(negedge clk);
        ent_acc += $countones(ent_w);
        ext_acc += $countones(ext_w);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic rst, clr; logic [1:0] a, b; int cyc;
        int cnt; logic [1:0] eseq; logic ovf, unf; int nent, next;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v(input logic r, input logic c, input logic [1:0] a, input logic [1:0] b,
                               input int n, input int cnt, input logic [1:0] es,
                               input logic ov, input logic un, input int ne, input int nx);
        vec_t t;
        t.rst = r; t.clr = c; t.a = a; t.b = b; t.cyc = n; t.cnt = cnt;
        t.eseq = es; t.ovf = ov; t.unf = un; t.nent = ne; t.next = nx;
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int rw_pos[2], rw_dir[2];
    logic [1:0] raw;

    initial begin
        rst = 0; clr_err = 0; A = 0; B = 0;
        // reset
        tbl.push_back(v(0,0,2'b00,2'b00, 3, 0,2'b00,0,0,0,0));
        // lane0 entry 0->1
        tbl.push_back(v(1,0,2'b01,2'b00,10, 0,2'b00,0,0,0,0));
        tbl.push_back(v(1,0,2'b01,2'b01,10, 0,2'b00,0,0,0,0));
        tbl.push_back(v(1,0,2'b00,2'b01,10, 0,2'b00,0,0,0,0));
        tbl.push_back(v(1,0,2'b00,2'b00,10, 1,2'b00,0,0,1,0));
        // lane1 exit 1->0
        tbl.push_back(v(1,0,2'b00,2'b10,10, 1,2'b00,0,0,0,0));
        tbl.push_back(v(1,0,2'b10,2'b10,10, 1,2'b00,0,0,0,0));
        tbl.push_back(v(1,0,2'b10,2'b00,10, 1,2'b00,0,0,0,0));
        tbl.push_back(v(1,0,2'b00,2'b00,10, 0,2'b00,0,0,0,1));
        // lane0 illegal 00->11->00, then clear
        tbl.push_back(v(1,0,2'b01,2'b01, 5, 0,2'b01,0,0,0,0));
        tbl.push_back(v(1,0,2'b00,2'b00, 5, 0,2'b01,0,0,0,0));
        tbl.push_back(v(1,1,2'b00,2'b00, 1, 0,2'b00,0,0,0,0));
        // both lanes enter together twice: 0->2, 2->3 saturated
        for (int k = 0; k < 2; k++) begin
            tbl.push_back(v(1,0,2'b11,2'b00,10, 2*k,2'b00,0,0,0,0));
            tbl.push_back(v(1,0,2'b11,2'b11,10, 2*k,2'b00,0,0,0,0));
            tbl.push_back(v(1,0,2'b00,2'b11,10, 2*k,2'b00,0,0,0,0));
        tbl.push_back(v(1,0,2'b00,2'b00,10, (k==0)?2:3,2'b00,k==1,0,2,0));
        end
        tbl.push_back(v(1,1,2'b00,2'b00, 1, 3,2'b00,0,0,0,0));
        // lane0 backs out
        tbl.push_back(v(1,0,2'b01,2'b00, 5, 3,2'b00,0,0,0,0));
        tbl.push_back(v(1,0,2'b01,2'b01, 5, 3,2'b00,0,0,0,0));
        tbl.push_back(v(1,0,2'b01,2'b00, 5, 3,2'b00,0,0,0,0));
        tbl.push_back(v(1,0,2'b00,2'b00, 8, 3,2'b00,0,0,0,0));
        // both lanes exit twice: 3->1, 1->0 underflow
        for (int k = 0; k < 2; k++) begin
            tbl.push_back(v(1,0,2'b00,2'b11,10, 3-2*k,2'b00,0,0,0,0));
            tbl.push_back(v(1,0,2'b11,2'b11,10, 3-2*k,2'b00,0,0,0,0));
            tbl.push_back(v(1,0,2'b11,2'b00,10, 3-2*k,2'b00,0,0,0,0));
            tbl.push_back(v(1,0,2'b00,2'b00,10, (k==0)?1:0,2'b00,0,k==1,0,2));
        end
        tbl.push_back(v(1,1,2'b00,2'b00, 1, 0,2'b00,0,0,0,0));
        // lane1 exit from empty
        tbl.push_back(v(1,0,2'b00,2'b10,10, 0,2'b00,0,0,0,0));
        tbl.push_back(v(1,0,2'b10,2'b10,10, 0,2'b00,0,0,0,0));
        tbl.push_back(v(1,0,2'b10,2'b00,10, 0,2'b00,0,0,0,0));
        tbl.push_back(v(1,0,2'b00,2'b00,10, 0,2'b00,0,1,0,1));
        tbl.push_back(v(1,1,2'b00,2'b00, 1, 0,2'b00,0,0,0,0));
        // reset while lane0 sits in EN3 (count 1, lane1 flagged)
        tbl.push_back(v(1,0,2'b01,2'b00,10, 0,2'b00,0,0,0,0));
        tbl.push_back(v(1,0,2'b01,2'b01,10, 0,2'b00,0,0,0,0));
        tbl.push_back(v(1,0,2'b00,2'b01,10, 0,2'b00,0,0,0,0));
        tbl.push_back(v(1,0,2'b00,2'b00,10, 1,2'b00,0,0,1,0));
        tbl.push_back(v(1,0,2'b10,2'b10, 5, 1,2'b10,0,0,0,0));
        tbl.push_back(v(1,0,2'b11,2'b10, 5, 1,2'b10,0,0,0,0));
        tbl.push_back(v(1,0,2'b11,2'b11, 5, 1,2'b10,0,0,0,0));
        tbl.push_back(v(1,0,2'b10,2'b11, 5, 1,2'b10,0,0,0,0));
        tbl.push_back(v(0,0,2'b10,2'b11, 2, 0,2'b00,0,0,0,0));
        // held pairs restart: lane0 01 opens an exit, lane1 11 is illegal
        tbl.push_back(v(1,0,2'b10,2'b11, 5, 0,2'b10,0,0,0,0));
        tbl.push_back(v(1,0,2'b00,2'b00, 8, 0,2'b10,0,0,0,0));

        foreach (tbl[k]) begin
            rst = tbl[k].rst; clr_err = tbl[k].clr; A = tbl[k].a; B = tbl[k].b;
            ent_acc = 0; ext_acc = 0;
            repeat (tbl[k].cyc) cyc();
            chk($sformatf("step%0d count", k), cnt_w, tbl[k].cnt);
            chk($sformatf("step%0d full", k), full_w, tbl[k].cnt == CAP);
            chk($sformatf("step%0d empty", k), empty_w, tbl[k].cnt == 0);
            chk($sformatf("step%0d err_seq", k), eseq_w, tbl[k].eseq);
            chk($sformatf("step%0d err_ovf", k), ovf_w, tbl[k].ovf);
            chk($sformatf("step%0d err_unf", k), unf_w, tbl[k].unf);
            chk($sformatf("step%0d entry_pulses", k), ent_acc, tbl[k].nent);
            chk($sformatf("step%0d exit_pulses", k), ext_acc, tbl[k].next);
        end

        // exact latency: raw 00 to entry pulse on the 3rd edge, count on the 4th
        clr_err = 1; cyc(); clr_err = 0;
        A = 2'b01; B = 2'b00; repeat (5) cyc();
        A = 2'b01; B = 2'b01; repeat (5) cyc();
        A = 2'b00; B = 2'b01; repeat (5) cyc();
        A = 2'b00; B = 2'b00;
        for (int e = 1; e <= 5; e++) begin
            cyc();
            chk($sformatf("lat edge%0d entry", e), ent_w, (e == 3) ? 2'b01 : 2'b00);
            chk($sformatf("lat edge%0d count", e), cnt_w, (e >= 4) ? 1 : 0);
            chk($sformatf("lat edge%0d empty", e), empty_w, (e >= 4) ? 0 : 1);
        end

        // random lane walks with occasional glitches, clears and resets
        for (int i = 0; i < 2; i++) begin rw_pos[i] = 0; rw_dir[i] = 0; end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 99) < 10) raw = 2'($urandom_range(0, 3));
                    else begin
                        if (rw_pos[i] == 0) begin
                            rw_dir[i] = $urandom_range(0, 1);
                            rw_pos[i] = 1;
                        end else if ($urandom_range(0, 99) < 70) rw_pos[i] = (rw_pos[i] == 3) ? 0 : rw_pos[i] + 1;
                        else rw_pos[i] = rw_pos[i] - 1;
                        raw = (rw_pos[i] == 0) ? 2'b00 : pth(rw_dir[i], rw_pos[i] - 1);
                    end
                    A[i] = raw[1]; B[i] = raw[0];
                end
            end
            clr_err = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 299) != 0);
            cyc();
            chk("rnd entry", ent_w, m_ent);
            chk("rnd exit", ext_w, m_ext);
            chk("rnd count", cnt_w, m_cnt);
            chk("rnd full", full_w, m_cnt == CAP);
            chk("rnd empty", empty_w, m_cnt == 0);
            chk("rnd err_seq", eseq_w, m_eseq);
            chk("rnd err_ovf", ovf_w, m_ovf);
            chk("rnd err_unf", unf_w, m_unf);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
